// File: rtl/sdf_seq_pkg.sv
// Shared definitions for the SDF test-cone vector sequencer.
//   - seq_state_e : sequencer FSM states
//   - IdxD1/IdxD2/IdxEn : bit positions of d1/d2/en inside a 3-bit vector {en,d2,d1}
//   - NumVec : number of input combinations walked per pass
//   - sdf_golden() : expected {q3,q2,q1} of the cone for a given {en,d2,d1}
package sdf_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StCheck
    } seq_state_e;

    localparam int unsigned IdxD1  = 0;
    localparam int unsigned IdxD2  = 1;
    localparam int unsigned IdxEn  = 2;
    localparam int unsigned NumVec = 8;

    // n5 is the shared buf/or node of the cone; q2 is the nand of n5 with en.
    function automatic logic [2:0] sdf_golden(input logic [2:0] vec);
        logic d1;
        logic d2;
        logic en;
        logic n5;
        d1 = vec[IdxD1];
        d2 = vec[IdxD2];
        en = vec[IdxEn];
        n5 = ~d1 | d2;
        return {d1 & d2, ~(n5 & en), n5};
    endfunction

endpackage

// File: rtl/sdf_golden_model.sv
// Combinational expected-output generator for the SDF test cone.
// Ports:
//   vec_i : applied vector {en,d2,d1}
//   exp_o : expected captured outputs {q3,q2,q1}
module sdf_golden_model
    import sdf_seq_pkg::*;
(
    input  logic [2:0] vec_i,
    output logic [2:0] exp_o
);

    assign exp_o = sdf_golden(vec_i);

endmodule

// File: rtl/sdf_vec_sequencer.sv
// Drives all eight {en,d2,d1} combinations into the SDF test cone for NUM_PASSES sweeps,
// checks the captured q1..q3 against the golden model and reports the result.
// Ports:
//   clk, rst_n        : clock (rising edge) and asynchronous active-low reset
//   start             : single-cycle run request, honoured only when idle
//   abort             : return to idle from any state, results so far are kept
//   q1, q2, q3        : captured outputs of the cone under test
//   d1, d2, en        : registered vector driven into the cone
//   busy              : high while a run is in progress
//   done              : one-cycle pulse when a run completes (not on abort)
//   pass              : sticky, last completed run had no mismatches
//   err_cnt           : saturating count of mismatching vectors
//   fail_vec          : {en,d2,d1} of the first mismatch
//   fail_mask         : {q3,q2,q1} mismatch bits of the first mismatch
module sdf_vec_sequencer
    import sdf_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned NUM_PASSES    = 1,
    parameter int unsigned ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             q1,
    input  logic             q2,
    input  logic             q3,
    output logic             d1,
    output logic             d2,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       fail_vec,
    output logic [2:0]       fail_mask
);

    localparam int unsigned WaitW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int unsigned PassW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    localparam logic [WaitW-1:0] WaitInit = WaitW'(SETTLE_CYCLES);
    localparam logic [PassW-1:0] PassLast = PassW'(NUM_PASSES - 1);
    localparam logic [2:0]       VecLast  = 3'(NumVec - 1);
    localparam logic [ERR_W-1:0] ErrMax   = '1;

    seq_state_e       state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [PassW-1:0] pass_cnt_q, pass_cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [2:0]       fail_vec_q, fail_vec_d;
    logic [2:0]       fail_mask_q, fail_mask_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;

    logic [2:0]       exp_q;
    logic [2:0]       mm;
    logic [ERR_W-1:0] err_inc;
    logic [ERR_W-1:0] err_after;
    logic             last_check;

    sdf_golden_model u_golden (
        .vec_i (vec_q),
        .exp_o (exp_q)
    );

    assign mm         = {q3, q2, q1} ^ exp_q;
    assign err_inc    = (err_q == ErrMax) ? err_q : err_q + ERR_W'(1);
    assign err_after  = (mm != 3'b000) ? err_inc : err_q;
    assign last_check = (vec_q == VecLast) && (pass_cnt_q == PassLast);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (wait_cnt_q == '0) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (abort || last_check) begin
                    state_d = StIdle;
                end else begin
                    state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q       <= 3'b000;
            wait_cnt_q  <= '0;
            pass_cnt_q  <= '0;
            err_q       <= '0;
            fail_vec_q  <= 3'b000;
            fail_mask_q <= 3'b000;
            pass_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            vec_q       <= vec_d;
            wait_cnt_q  <= wait_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            err_q       <= err_d;
            fail_vec_q  <= fail_vec_d;
            fail_mask_q <= fail_mask_d;
            pass_q      <= pass_d;
            done_q      <= done_d;
        end
    end

    // Datapath next-state and result bookkeeping
    always_comb begin
        vec_d       = vec_q;
        wait_cnt_d  = wait_cnt_q;
        pass_cnt_d  = pass_cnt_q;
        err_d       = err_q;
        fail_vec_d  = fail_vec_q;
        fail_mask_d = fail_mask_q;
        pass_d      = pass_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    vec_d       = 3'b000;
                    wait_cnt_d  = WaitInit;
                    pass_cnt_d  = '0;
                    err_d       = '0;
                    fail_vec_d  = 3'b000;
                    fail_mask_d = 3'b000;
                    pass_d      = 1'b0;
                end
            end
            StWait: begin
                if (abort) begin
                    vec_d = 3'b000;
                end else if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - WaitW'(1);
                end
            end
            StCheck: begin
                if (abort) begin
                    // Abort wins over the check in flight: results stay as they were.
                    vec_d = 3'b000;
                end else begin
                    err_d = err_after;
                    if ((mm != 3'b000) && (err_q == '0)) begin
                        fail_vec_d  = vec_q;
                        fail_mask_d = mm;
                    end
                    wait_cnt_d = WaitInit;
                    if (last_check) begin
                        vec_d  = 3'b000;
                        done_d = 1'b1;
                        pass_d = (err_after == '0);
                    end else if (vec_q == VecLast) begin
                        vec_d      = 3'b000;
                        pass_cnt_d = pass_cnt_q + PassW'(1);
                    end else begin
                        vec_d = vec_q + 3'd1;
                    end
                end
            end
            default: vec_d = 3'b000;
        endcase
    end

    // Outputs straight from flops, apart from busy which is a decode of the state flop.
    always_comb begin
        d1        = vec_q[IdxD1];
        d2        = vec_q[IdxD2];
        en        = vec_q[IdxEn];
        busy      = (state_q != StIdle);
        done      = done_q;
        pass      = pass_q;
        err_cnt   = err_q;
        fail_vec  = fail_vec_q;
        fail_mask = fail_mask_q;
    end

endmodule

// File: tb/tb_sdf_vec_sequencer.sv
module tb_sdf_vec_sequencer;

    localparam int SETTLE_B = 2;
    localparam int PASSES_B = 2;
    localparam int ERRW_B   = 2;

    typedef struct {
        int         err;
        logic [2:0] fv;
        logic [2:0] fm;
        logic       pass;
        int         cycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic abort = 1'b0;

    int mode_a = 0;
    int mode_b = 0;

    logic [2:0] q_a = 3'b000;
    logic [2:0] q_b = 3'b000;
    logic d1_a, d2_a, en_a, busy_a, done_a, pass_a;
    logic d1_b, d2_b, en_b, busy_b, done_b, pass_b;
    logic [3:0] err_a;
    logic [ERRW_B-1:0] err_b;
    logic [2:0] fv_a, fm_a, fv_b, fm_b;

    logic [2:0] gvec = 3'b000;
    logic [2:0] gexp;

    int n_tests = 0;
    int n_fail = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    sdf_vec_sequencer #(.SETTLE_CYCLES(1), .NUM_PASSES(1), .ERR_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
        .q1(q_a[0]), .q2(q_a[1]), .q3(q_a[2]),
        .d1(d1_a), .d2(d2_a), .en(en_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .fail_vec(fv_a), .fail_mask(fm_a)
    );

    sdf_vec_sequencer #(.SETTLE_CYCLES(SETTLE_B), .NUM_PASSES(PASSES_B), .ERR_W(ERRW_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
        .q1(q_b[0]), .q2(q_b[1]), .q3(q_b[2]),
        .d1(d1_b), .d2(d2_b), .en(en_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .fail_vec(fv_b), .fail_mask(fm_b)
    );

    sdf_golden_model u_gold (
        .vec_i (gvec),
        .exp_o (gexp)
    );

    // Cone behaviour written out from the gate description: {q3,q2,q1} for {en,d2,d1}.
    function automatic logic [2:0] ref_q(input logic [2:0] v);
        logic d1, d2, en;
        d1 = v[0];
        d2 = v[1];
        en = v[2];
        return {d1 & d2, ~((~d1 | d2) & en), ~d1 | d2};
    endfunction

    // mode 0: healthy cone, 1: q2 stuck at 0, 2: all outputs inverted
    function automatic logic [2:0] cone_f(input int mode, input logic [2:0] v);
        logic [2:0] r;
        r = ref_q(v);
        if (mode == 1) r[1] = 1'b0;
        else if (mode == 2) r = ~r;
        return r;
    endfunction

    // Bench-side cone with one capture flop per output.
    always_ff @(posedge clk) begin
        q_a <= cone_f(mode_a, {en_a, d2_a, d1_a});
        q_b <= cone_f(mode_b, {en_b, d2_b, d1_b});
    end

    function automatic exp_t build_exp(input int mode, input int settle, input int passes,
                                       input int nchk, input int errmax);
        exp_t e;
        logic [2:0] v, mm;
        e.err = 0;
        e.fv = 3'b000;
        e.fm = 3'b000;
        e.cycles = passes * 8 * (settle + 2);
        for (int k = 0; k < nchk; k++) begin
            v = 3'(k % 8);
            mm = cone_f(mode, v) ^ ref_q(v);
            if (mm != 3'b000) begin
                if (e.err == 0) begin
                    e.fv = v;
                    e.fm = mm;
                end
                if (e.err < errmax) e.err++;
            end
        end
        e.pass = (nchk == passes * 8) && (e.err == 0);
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic run_seq(input bit use_b, input int mode, input int repulse_at);
        exp_t e;
        int cyc;
        bit got;
        if (use_b) begin
            mode_b = mode;
            sb_q.push_back(build_exp(mode, SETTLE_B, PASSES_B, PASSES_B * 8, (1 << ERRW_B) - 1));
        end else begin
            mode_a = mode;
            sb_q.push_back(build_exp(mode, 1, 1, 8, 15));
        end
        @(negedge clk);
        if (use_b) start_b = 1'b1;
        else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 500) begin
            @(posedge clk);
            cyc++;
            #1;
            start_a = !use_b && (cyc == repulse_at);
            if (use_b ? done_b : done_a) got = 1'b1;
        end
        start_a = 1'b0;
        e = sb_q.pop_front();
        check_eq("done_seen", 32'(got), 32'd1);
        if (got) begin
            check_eq("run_cycles", 32'(cyc), 32'(e.cycles));
            if (use_b) begin
                check_eq("b_err_cnt", 32'(err_b), 32'(e.err));
                check_eq("b_fail_vec", 32'(fv_b), 32'(e.fv));
                check_eq("b_fail_mask", 32'(fm_b), 32'(e.fm));
                check_eq("b_pass", 32'(pass_b), 32'(e.pass));
                check_eq("b_idle_vec", 32'({busy_b, en_b, d2_b, d1_b}), 32'd0);
            end else begin
                check_eq("a_err_cnt", 32'(err_a), 32'(e.err));
                check_eq("a_fail_vec", 32'(fv_a), 32'(e.fv));
                check_eq("a_fail_mask", 32'(fm_a), 32'(e.fm));
                check_eq("a_pass", 32'(pass_a), 32'(e.pass));
                check_eq("a_idle_vec", 32'({busy_a, en_a, d2_a, d1_a}), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        check_eq("done_pulse", 32'(use_b ? done_b : done_a), 32'd0);
    endtask

    task automatic expect_no_done(input string tag, input int ncyc);
        int seen;
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (done_a) seen++;
        end
        check_eq(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", 32'({busy_a, done_a, pass_a, d1_a, d2_a, en_a, err_a, fv_a, fm_a}),
                 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("post_reset_busy", 32'({busy_a, busy_b}), 32'd0);

        // Golden model against the written-out cone equations.
        for (int v = 0; v < 8; v++) begin
            gvec = 3'(v);
            #1;
            check_eq($sformatf("golden_%0d", v), 32'(gexp), 32'(ref_q(3'(v))));
        end
        gvec = 3'b101;
        #1;
        check_eq("golden_101", 32'(gexp), 32'b010);

        run_seq(1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("pass_sticky", 32'(pass_a), 32'd1);

        run_seq(1'b0, 1, 0);
        run_seq(1'b1, 2, 0);

        // Abort part way through: three vectors have been checked by edge 9.
        mode_a = 1;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        e = build_exp(1, 1, 1, 3, 15);
        check_eq("abort_busy", 32'(busy_a), 32'd0);
        check_eq("abort_vec", 32'({en_a, d2_a, d1_a}), 32'd0);
        check_eq("abort_err", 32'(err_a), 32'(e.err));
        check_eq("abort_fail_vec", 32'(fv_a), 32'(e.fv));
        check_eq("abort_fail_mask", 32'(fm_a), 32'(e.fm));
        check_eq("abort_pass", 32'(pass_a), 32'd0);
        expect_no_done("abort_no_done", 30);
        run_seq(1'b0, 0, 0);

        // start and abort together while idle: nothing happens.
        @(negedge clk);
        start_a = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        abort = 1'b0;
        check_eq("start_abort_idle", 32'(busy_a), 32'd0);
        expect_no_done("start_abort_no_done", 5);

        // start re-pulsed mid-run is ignored.
        run_seq(1'b0, 1, 7);

        // Asynchronous reset in the middle of a WAIT.
        mode_a = 1;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_eq("pre_reset_busy", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_outs",
                 32'({busy_a, done_a, pass_a, d1_a, d2_a, en_a, err_a, fv_a, fm_a}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expect_no_done("reset_no_done", 30);
        check_eq("reset_idle_busy", 32'(busy_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
